// File: rtl/rgb_pwm_fader.sv
// rgb_pwm_fader: multi-channel PWM LED driver with per-channel off / steady /
// blink / breathe modes sharing one triangle brightness ramp.
//
// Ports:
//   clock        - system clock, all logic on its rising edge
//   reset_n      - asynchronous active-low reset
//   enable       - high runs the counters; low freezes them and blanks the LEDs
//   mode         - per-channel mode, channel i at [2i+1:2i]
//                  (00 off, 01 steady, 10 blink, 11 breathe)
//   duty         - per-channel duty / breathe peak, channel i at [W*i+W-1:W*i]
//   led          - registered PWM outputs, polarity set by ACTIVE_LOW
//   period_start - one-cycle pulse after each PWM period wrap
module rgb_pwm_fader #(
  parameter int unsigned CHANNELS     = 3,
  parameter int unsigned PWM_WIDTH    = 8,
  parameter int unsigned PRESCALE     = 12,
  parameter int unsigned STEP_PERIODS = 4,
  parameter int unsigned ACTIVE_LOW   = 1
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic [2*CHANNELS-1:0]           mode,
  input  logic [PWM_WIDTH*CHANNELS-1:0]   duty,
  output logic [CHANNELS-1:0]             led,
  output logic                            period_start
);

  localparam int unsigned W      = PWM_WIDTH;
  localparam int unsigned PW2    = 2 * PWM_WIDTH;
  localparam int unsigned PSC_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned STEP_W = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;
  localparam logic        AL     = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'b00,
    MODE_STEADY  = 2'b01,
    MODE_BLINK   = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [PSC_W-1:0]  psc_q, psc_d;
  logic [W-1:0]      pwm_cnt_q, pwm_cnt_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [W-1:0]      r_q, r_d;
  dir_e              dir_q, dir_d;
  mode_e             mode_sh_q [CHANNELS];
  logic [W-1:0]      duty_sh_q [CHANNELS];
  logic [CHANNELS-1:0] led_q, led_d;
  logic              ps_q;

  logic              tick;
  logic              wrap;
  logic [W:0]        dplus [CHANNELS];
  logic [PW2-1:0]    prod  [CHANNELS];
  logic [W-1:0]      level [CHANNELS];
  logic [CHANNELS-1:0] raw;

  // Counter chain: prescaler -> PWM counter -> step counter -> ramp.
  always_comb begin
    tick      = enable && (psc_q == PSC_W'(PRESCALE - 1));
    wrap      = tick && (pwm_cnt_q == '1);

    psc_d     = psc_q;
    if (enable) psc_d = tick ? '0 : psc_q + 1'b1;

    pwm_cnt_d = tick ? pwm_cnt_q + 1'b1 : pwm_cnt_q;

    step_d    = step_q;
    r_d       = r_q;
    dir_d     = dir_q;
    if (wrap) begin
      if (step_q == STEP_W'(STEP_PERIODS - 1)) begin
        step_d = '0;
        if (dir_q == DIR_UP) begin
          if (r_q == '1) begin
            dir_d = DIR_DOWN;
            r_d   = r_q - 1'b1;
          end else begin
            r_d   = r_q + 1'b1;
          end
        end else begin
          if (r_q == '0) begin
            dir_d = DIR_UP;
            r_d   = r_q + 1'b1;
          end else begin
            r_d   = r_q - 1'b1;
          end
        end
      end else begin
        step_d = step_q + 1'b1;
      end
    end
  end

  // Per-channel level from the shadow copies, so a period sees one setting only.
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      dplus[i] = {1'b0, duty_sh_q[i]} + 1'b1;
      // Peak+1 scaling makes a full-scale peak reproduce the ramp exactly.
      prod[i]  = PW2'(r_q) * PW2'(dplus[i]);
      level[i] = '0;
      unique case (mode_sh_q[i])
        MODE_OFF:     level[i] = '0;
        MODE_STEADY:  level[i] = duty_sh_q[i];
        MODE_BLINK:   level[i] = (dir_q == DIR_UP) ? duty_sh_q[i] : '0;
        MODE_BREATHE: level[i] = prod[i][PW2-1:W];
        default:      level[i] = '0;
      endcase
      raw[i] = pwm_cnt_q < level[i];
    end
    led_d = (enable ? raw : '0) ^ {CHANNELS{AL}};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      psc_q     <= '0;
      pwm_cnt_q <= '0;
      step_q    <= '0;
      r_q       <= '0;
      dir_q     <= DIR_UP;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        mode_sh_q[i] <= MODE_OFF;
        duty_sh_q[i] <= '0;
      end
      led_q     <= {CHANNELS{AL}};
      ps_q      <= 1'b0;
    end else begin
      psc_q     <= psc_d;
      pwm_cnt_q <= pwm_cnt_d;
      step_q    <= step_d;
      r_q       <= r_d;
      dir_q     <= dir_d;
      if (wrap) begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          mode_sh_q[i] <= mode_e'(mode[2*i +: 2]);
          duty_sh_q[i] <= duty[W*i +: W];
        end
      end
      led_q     <= led_d;
      ps_q      <= wrap;
    end
  end

  assign led          = led_q;
  assign period_start = ps_q;

endmodule

// File: tb/tb_rgb_pwm_fader.sv
module tb_rgb_pwm_fader;

  localparam int CH   = 3;
  localparam int W    = 4;
  localparam int N    = 16;
  localparam int P    = 2;
  localparam int STEP = 2;
  localparam int AL   = 1;
  localparam int PER  = N * P;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic [2*CH-1:0]   mode;
  logic [W*CH-1:0]   duty;
  logic [CH-1:0]     led;
  logic              ps;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: enabled cycles since reset plus latched settings.
  int           t;
  int           sh_mode [CH];
  int           sh_duty [CH];
  logic [CH-1:0] eled;
  logic          eps;

  rgb_pwm_fader #(
    .CHANNELS(CH), .PWM_WIDTH(W), .PRESCALE(P),
    .STEP_PERIODS(STEP), .ACTIVE_LOW(AL)
  ) dut (
    .clock(clk), .reset_n(rst_n), .enable(en), .mode(mode), .duty(duty),
    .led(led), .period_start(ps)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int ramp_r(input int s);
    int p;
    if (s == 0) return 0;
    p = (s - 1) % (2 * (N - 1));
    return (p < N - 1) ? p + 1 : 2 * (N - 1) - 1 - p;
  endfunction

  function automatic bit ramp_up(input int s);
    if (s == 0) return 1'b1;
    return ((s - 1) % (2 * (N - 1))) < N - 1;
  endfunction

  function automatic int level_of(input int m, input int d, input int s);
    case (m)
      1:       return d;
      2:       return ramp_up(s) ? d : 0;
      3:       return (ramp_r(s) * (d + 1)) / N;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    t = 0;
    for (int i = 0; i < CH; i++) begin
      sh_mode[i] = 0;
      sh_duty[i] = 0;
    end
    eled = {CH{1'b1}};
    eps  = 1'b0;
  endtask

  task automatic set_ch(input int ch, input int m, input int d);
    mode[2*ch +: 2] = 2'(m);
    duty[W*ch +: W] = 4'(d);
  endtask

  // One clock: advance the model from pre-edge inputs, then compare outputs.
  task automatic tick();
    int cnt, s, lvl;
    bit wrap;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      cnt = (t / P) % N;
      s   = (t / PER) / STEP;
      for (int i = 0; i < CH; i++) begin
        lvl = level_of(sh_mode[i], sh_duty[i], s);
        eled[i] = ((en && cnt < lvl) ? 1'b1 : 1'b0) ^ 1'(AL);
      end
      wrap = en && ((t % PER) == PER - 1);
      eps  = wrap;
      if (wrap) begin
        for (int i = 0; i < CH; i++) begin
          sh_mode[i] = int'(mode[2*i +: 2]);
          sh_duty[i] = int'(duty[W*i +: W]);
        end
      end
      if (en) t++;
    end
    #1;
    check("model_led", 32'(led), 32'(eled));
    check("model_period_start", 32'(ps), 32'(eps));
  endtask

  task automatic wait_ps(input string nm, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!ps && n < 300);
    check(nm, 32'(ps), 32'd1);
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_led", 32'(led), 32'(3'b111));
    check("async_reset_ps", 32'(ps), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [1:0] m;
    logic [3:0] d;
    int         exp_on;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int n, on, on_other, en_cnt;
    bit first_on;

    vecs[0] = '{2'b01, 4'd4,  8};
    vecs[1] = '{2'b01, 4'd0,  0};
    vecs[2] = '{2'b01, 4'd15, 30};
    vecs[3] = '{2'b01, 4'd1,  2};
    vecs[4] = '{2'b00, 4'd9,  0};
    vecs[5] = '{2'b01, 4'd8,  16};

    rst_n = 1'b0;
    en    = 1'b1;
    mode  = '0;
    duty  = '0;
    model_reset();
    tick();
    tick();
    check("reset_led", 32'(led), 32'(3'b111));
    check("reset_ps", 32'(ps), 32'd0);
    rst_n = 1'b1;
    wait_ps("first_ps", n);
    check("first_ps_latency", 32'(n), 32'(PER));

    // Steady duty table on channel 0.
    for (int v = 0; v < 6; v++) begin
      set_ch(0, int'(vecs[v].m), int'(vecs[v].d));
      set_ch(1, 0, 15);
      set_ch(2, 0, 15);
      wait_ps("tbl_sync", n);
      on = 0;
      on_other = 0;
      for (int i = 0; i < PER; i++) begin
        tick();
        if (!led[0]) on++;
        if (led[2:1] != 2'b11) on_other++;
      end
      check($sformatf("tbl%0d_on", v), 32'(on), 32'(vecs[v].exp_on));
      check($sformatf("tbl%0d_others_off", v), 32'(on_other), 32'd0);
      check($sformatf("tbl%0d_ps", v), 32'(ps), 32'd1);
    end

    // Duty change mid-period takes effect only at the boundary.
    set_ch(0, 1, 4);
    wait_ps("chg_sync", n);
    wait_ps("chg_sync2", n);
    on = 0;
    for (int i = 0; i < PER; i++) begin
      tick();
      if (!led[0]) on++;
      if (i == 4) set_ch(0, 1, 12);
    end
    check("chg_old_period_on", 32'(on), 32'd8);
    on = 0;
    for (int i = 0; i < PER; i++) begin
      tick();
      if (i == 0) first_on = !led[0];
      if (!led[0]) on++;
      if (i == 6) set_ch(0, 1, 0);
      if (i == 9) set_ch(0, 1, 12);
    end
    check("chg_first_cycle_on", 32'(first_on), 32'd1);
    check("chg_new_period_on", 32'(on), 32'd24);
    on = 0;
    for (int i = 0; i < PER; i++) begin
      tick();
      if (!led[0]) on++;
    end
    check("revert_invisible_on", 32'(on), 32'd24);

    // Enable dropped for 100 cycles mid-period.
    on = 0;
    en_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      en_cnt++;
      if (!led[0]) on++;
    end
    en = 1'b0;
    on_other = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (led != 3'b111 || ps) on_other++;
    end
    check("disabled_outputs_idle", 32'(on_other), 32'd0);
    en = 1'b1;
    do begin
      tick();
      en_cnt++;
      if (!led[0]) on++;
    end while (!ps && en_cnt < 300);
    check("resume_period_len", 32'(en_cnt), 32'(PER));
    check("resume_on_total", 32'(on), 32'd24);

    // Asynchronous reset while channel 0 is lit.
    set_ch(0, 1, 15);
    wait_ps("rst_sync", n);
    wait_ps("rst_sync2", n);
    tick();
    tick();
    tick();
    check("pre_reset_lit", 32'(led[0]), 32'd0);
    do_reset();
    wait_ps("rst_first_ps", n);
    check("rst_first_ps_latency", 32'(n), 32'(PER));

    // Blink / breathe sequence from reset.
    set_ch(0, 2, 9);
    set_ch(1, 3, 15);
    set_ch(2, 3, 7);
    do_reset();
    wait_ps("brth_sync", n);
    for (int k = 1; k <= 64; k++) begin
      int c0, c1, c2, s;
      c0 = 0; c1 = 0; c2 = 0;
      s = k / STEP;
      for (int i = 0; i < PER; i++) begin
        tick();
        if (!led[0]) c0++;
        if (!led[1]) c1++;
        if (!led[2]) c2++;
      end
      check($sformatf("blink_p%0d", k), 32'(c0), 32'((ramp_up(s) ? 9 : 0) * P));
      check($sformatf("breathe15_p%0d", k), 32'(c1), 32'(ramp_r(s) * P));
      check($sformatf("breathe7_p%0d", k), 32'(c2), 32'(((ramp_r(s) * 8) / N) * P));
    end

    // Random settings and enable toggling against the model.
    for (int i = 0; i < 3000; i++) begin
      tick();
      if ($urandom_range(0, 19) == 0)
        set_ch(int'($urandom_range(0, CH - 1)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 15)));
      if ($urandom_range(0, 149) == 0) en = ~en;
    end
    en = 1'b1;
    for (int i = 0; i < PER; i++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
